// File: rtl/decode_issue_stage_pkg.sv
// decode_pkg: opcodes, cc bit positions and FSM states shared by the decode/issue stage
package decode_pkg;
  localparam logic [3:0] OP_LOAD = 4'b0010;
  localparam logic [3:0] OP_BRANCH = 4'b0011;
  localparam int CC_SRC_REG = 3;
  localparam int CC_DEST_REG = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} decode_state_t;
endpackage

// File: rtl/decode_issue_stage_if.sv
// decode_issue_stage_if: instruction-in and decoded-bundle-out handshakes of the decode/issue stage
interface decode_issue_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] instruction;
  logic out_valid;
  logic out_ready;
  logic [3:0] opcode;
  logic [3:0] cc;
  logic [DATA_WIDTH-1:0] operand_one;
  logic [DATA_WIDTH-1:0] operand_two;
  logic dest_type;
  logic [ADDRESS_WIDTH-1:0] dest_adrs;
  modport master (
    output in_valid, instruction, out_ready,
    input in_ready, out_valid, opcode, cc, operand_one, operand_two, dest_type, dest_adrs
  );
  modport slave (
    input in_valid, instruction, out_ready,
    output in_ready, out_valid, opcode, cc, operand_one, operand_two, dest_type, dest_adrs
  );
endinterface

// File: rtl/decode_issue_stage_scoreboard.sv
// decode_scoreboard: pending destination-write tracker; a same-cycle write-back is applied before lookup
module decode_scoreboard #(
  parameter int PENDING_DEPTH = 4,
  parameter int ADDRESS_WIDTH = 12
)(
  input  logic clk,
  input  logic rst,
  input  logic [ADDRESS_WIDTH-1:0] look_a,
  input  logic [ADDRESS_WIDTH-1:0] look_b,
  output logic pend_a,
  output logic pend_b,
  output logic full,
  input  logic alloc,
  input  logic [ADDRESS_WIDTH-1:0] alloc_adrs,
  input  logic clr,
  input  logic [ADDRESS_WIDTH-1:0] clr_adrs
);
  logic [PENDING_DEPTH-1:0] valid, eff, nxt;
  logic [ADDRESS_WIDTH-1:0] adrs [PENDING_DEPTH];
  logic hit, found;
  always_comb begin
    eff = valid;
    hit = 1'b0;
    for (int i = 0; i < PENDING_DEPTH; i++)
      if (clr && !hit && valid[i] && adrs[i] == clr_adrs) begin
        eff[i] = 1'b0;
        hit = 1'b1;
      end
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < PENDING_DEPTH; i++) begin
      pend_a = pend_a | (eff[i] && adrs[i] == look_a);
      pend_b = pend_b | (eff[i] && adrs[i] == look_b);
    end
    full = &eff;
    nxt = eff;
    found = 1'b0;
    for (int i = 0; i < PENDING_DEPTH; i++)
      if (alloc && !found && !eff[i]) begin
        nxt[i] = 1'b1;
        found = 1'b1;
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < PENDING_DEPTH; i++) adrs[i] <= '0;
    end else begin
      valid <= nxt;
      for (int i = 0; i < PENDING_DEPTH; i++) if (nxt[i] && !eff[i]) adrs[i] <= alloc_adrs;
    end
endmodule

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: registered decode with RF read issue and RAW-hazard stall.
// Optional DECODE_PERF_CNT_EN adds saturating decode_count/stall_count outputs.
module decode_issue_stage import decode_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int PENDING_DEPTH = 4
)(
  input  logic clk,
  input  logic rst,
  decode_issue_stage_if.slave io,
  input  logic flush,
  output logic rf_r_en_one,
  output logic rf_r_en_two,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_one,
  output logic [ADDRESS_WIDTH-1:0] rf_r_adrs_two,
  input  logic [DATA_WIDTH-1:0] rf_rdata_one,
  input  logic [DATA_WIDTH-1:0] rf_rdata_two,
  input  logic wb_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb_adrs,
  output logic stall_hazard
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0] decode_count,
  output logic [31:0] stall_count
`endif
);
  decode_state_t state, nstate;
  logic [DATA_WIDTH-1:0] inst;
  logic [3:0] op, ccf;
  logic [ADDRESS_WIDTH-1:0] src, dst;
  logic use_one, use_two, pend_a, pend_b, full, hazard, in_issue, retire;
  assign op = inst[DATA_WIDTH-1 -: 4];
  assign ccf = inst[DATA_WIDTH-5 -: 4];
  assign src = inst[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH];
  assign dst = inst[ADDRESS_WIDTH-1:0];
  assign use_two = ccf[CC_SRC_REG] | (op == OP_LOAD);
  assign use_one = ccf[CC_DEST_REG] & (op != OP_BRANCH);
  assign rf_r_adrs_one = dst;
  assign rf_r_adrs_two = src;
  assign hazard = (use_one & pend_a) | (use_two & pend_b) | (use_one & full);
  assign in_issue = state == ISSUE;
  assign stall_hazard = in_issue & hazard;
  assign rf_r_en_one = in_issue & !hazard & !flush & use_one;
  assign rf_r_en_two = in_issue & !hazard & !flush & use_two;
  assign io.out_valid = state == HOLD;
  assign io.in_ready = !flush & (state == IDLE | (state == HOLD & io.out_ready));
  assign retire = io.out_valid & io.out_ready & !flush;
  decode_scoreboard #(.PENDING_DEPTH(PENDING_DEPTH), .ADDRESS_WIDTH(ADDRESS_WIDTH)) u_sb (
    .clk(clk), .rst(rst),
    .look_a(dst), .look_b(src), .pend_a(pend_a), .pend_b(pend_b), .full(full),
    .alloc(retire & io.dest_type), .alloc_adrs(io.dest_adrs),
    .clr(wb_valid), .clr_adrs(wb_adrs)
  );
  always_comb begin
    nstate = state;
    if (flush) nstate = IDLE;
    else
      case (state)
        IDLE:    nstate = io.in_valid ? ISSUE : IDLE;
        ISSUE:   nstate = hazard ? ISSUE : CAPTURE;
        CAPTURE: nstate = HOLD;
        default: nstate = io.out_ready ? (io.in_valid ? ISSUE : IDLE) : HOLD;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nstate;
  always_ff @(posedge clk or posedge rst)
    if (rst) inst <= '0;
    else if (io.in_valid && io.in_ready) inst <= io.instruction;
  // Bundle is captured the cycle after the RF read so rf_rdata is valid
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      io.opcode <= '0;
      io.cc <= '0;
      io.operand_one <= '0;
      io.operand_two <= '0;
      io.dest_type <= 1'b0;
      io.dest_adrs <= '0;
    end else if (state == CAPTURE && !flush) begin
      io.opcode <= op;
      io.cc <= ccf;
      io.operand_one <= use_one ? rf_rdata_one : DATA_WIDTH'(dst);
      io.operand_two <= use_two ? rf_rdata_two : DATA_WIDTH'(src);
      io.dest_type <= use_one;
      io.dest_adrs <= dst;
    end
`ifdef DECODE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      decode_count <= '0;
      stall_count <= '0;
    end else begin
      if (io.out_valid && io.out_ready && !(&decode_count)) decode_count <= decode_count + 32'd1;
      if (stall_hazard && !(&stall_count)) stall_count <= stall_count + 32'd1;
    end
`endif
endmodule
